tt_pin_responder: RTL and testbench



---
 rtl/tt_pin_responder_pkg.sv | 28 ++
 rtl/tt_pin_responder_sync.sv | 26 ++
 rtl/tt_pin_responder.sv | 155 +++++++++++++++
 tb/tb_tt_pin_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pin_responder_pkg.sv
// Shared types and pin-bit constants for the tt_pin_responder register-access responder.
package tt_pin_responder_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CMD_ACK   = 2'd1,
        WAIT_DATA = 2'd2,
        DATA_ACK  = 2'd3
    } state_t;

    localparam int REQ_BIT       = 0;
    localparam int ACK_BIT       = 1;
    localparam int ERR_BIT       = 2;
    localparam int CMD_BIT       = 3;
    localparam int CMD_WRITE_BIT = 7;

    localparam logic [7:0] UIO_OE_MASK = 8'h06;

    // Place ack/err on their uio pins; all other uio outputs stay low.
    function automatic logic [7:0] pack_uio(input logic ack, input logic err);
        logic [7:0] r;
        r          = 8'h00;
        r[ACK_BIT] = ack;
        r[ERR_BIT] = err;
        return r;
    endfunction

endpackage

// File: rtl/tt_pin_responder_sync.sv
// Two-flop synchronizer for asynchronous host strobes, async active-low reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/tt_pin_responder.sv
// Byte-wide 4-phase req/ack register-file responder on the tt_um pin set.
// Optional write-burst auto-increment enabled by defining TT_PIN_RESPONDER_AUTOINC_EN.
module tt_pin_responder
    import tt_pin_responder_pkg::*;
#(
    parameter int         NREGS     = 16,
    parameter int         ADDR_W    = $clog2(NREGS),
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [1:0]        sync_q;
    logic              req_s;
    logic              cmd_s;
    logic              req_s_d_reg;
    logic              req_rise;
    logic              req_fall;

    state_t            state_reg;
    logic              ack_reg;
    logic              err_reg;
    logic [7:0]        uo_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              wr_oor_reg;
    logic              is_write_reg;

    logic [7:0]        regs_reg [NREGS];

    logic              cmd_is_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_oor;
    logic              cmd_capture;
    logic              data_fire;
    logic              wr_fire;

    sync_2ff #(.WIDTH(2)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({uio_in[CMD_BIT], uio_in[REQ_BIT]}),
        .q     (sync_q)
    );

    assign req_s = sync_q[0];
    assign cmd_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_s_d_reg <= 1'b0;
        end else begin
            req_s_d_reg <= req_s;
        end
    end

    // Edges come from synchronized history only, so a req already high when ena returns is ignored.
    assign req_rise = req_s & ~req_s_d_reg;
    assign req_fall = ~req_s & req_s_d_reg;

    assign cmd_is_write = ui_in[CMD_WRITE_BIT];
    assign cmd_addr     = ui_in[ADDR_W-1:0];
    assign cmd_oor      = |(ui_in[6:0] >> ADDR_W);

`ifdef TT_PIN_RESPONDER_AUTOINC_EN
    // Inside a burst the dedicated command strobe turns the byte into a fresh command.
    assign cmd_capture = ena && req_rise &&
                         ((state_reg == IDLE) || ((state_reg == WAIT_DATA) && cmd_s));
`else
    assign cmd_capture = ena && req_rise && (state_reg == IDLE);
`endif

    assign data_fire = ena && req_rise && (state_reg == WAIT_DATA) && !cmd_capture;
    assign wr_fire   = data_fire && !wr_oor_reg;

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs_reg[gi] <= RESET_VAL;
                end else if (wr_fire && (addr_reg == ADDR_W'(gi))) begin
                    regs_reg[gi] <= ui_in;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ack_reg      <= 1'b0;
            err_reg      <= 1'b0;
            uo_reg       <= 8'h00;
            addr_reg     <= '0;
            wr_oor_reg   <= 1'b0;
            is_write_reg <= 1'b0;
        end else if (!ena) begin
            state_reg <= IDLE;
            ack_reg   <= 1'b0;
        end else if (cmd_capture) begin
            ack_reg      <= 1'b1;
            err_reg      <= cmd_oor;
            is_write_reg <= cmd_is_write;
            state_reg    <= CMD_ACK;
            if (cmd_is_write) begin
                addr_reg   <= cmd_addr;
                wr_oor_reg <= cmd_oor;
            end else begin
                uo_reg <= cmd_oor ? 8'h00 : regs_reg[cmd_addr];
            end
        end else begin
            case (state_reg)
                CMD_ACK: begin
                    if (req_fall) begin
                        ack_reg   <= 1'b0;
                        state_reg <= is_write_reg ? WAIT_DATA : IDLE;
                    end
                end
                WAIT_DATA: begin
                    if (data_fire) begin
                        ack_reg   <= 1'b1;
                        state_reg <= DATA_ACK;
                    end
                end
                DATA_ACK: begin
                    if (req_fall) begin
                        ack_reg <= 1'b0;
`ifdef TT_PIN_RESPONDER_AUTOINC_EN
                        addr_reg  <= addr_reg + 1'b1;
                        state_reg <= WAIT_DATA;
`else
                        state_reg <= IDLE;
`endif
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign uo_out  = uo_reg;
    assign uio_out = pack_uio(ack_reg, err_reg);
    assign uio_oe  = UIO_OE_MASK;

    logic unused_bits;
    assign unused_bits = &{1'b0, uio_in[7:4], uio_in[2:1], cmd_s};

endmodule

// File: tb/tb_tt_pin_responder.sv
// Directed bench for tt_pin_responder with an expected-response queue per handshake phase.
module tb_tt_pin_responder;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b0;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    tt_pin_responder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] uo;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] mdl [16];
    logic [7:0] last_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] uo, input logic err);
        exp_t e;
        e.uo  = uo;
        e.err = err;
        sb.push_back(e);
    endtask

    task automatic req_up(input logic [7:0] b, input logic cmd_path, input string tag);
        int   n;
        exp_t e;
        @(negedge clk);
        ui_in  = b;
        uio_in = cmd_path ? 8'h09 : 8'h01;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (uio_out[1]) begin
                n = i;
                break;
            end
        end
        check({tag, " ack-rise latency"}, 32'(n), 32'd3);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " uo_out"}, 32'(uo_out), 32'(e.uo));
            check({tag, " err"}, 32'(uio_out[2]), 32'(e.err));
            $display("txn %s: byte=%02h uo_out=%02h err=%0b latency=%0d", tag, b, uo_out, uio_out[2], n);
        end
    endtask

    task automatic req_down(input string tag);
        int n;
        @(negedge clk);
        uio_in = 8'h00;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (!uio_out[1]) begin
                n = i;
                break;
            end
        end
        check({tag, " ack-fall latency"}, 32'(n), 32'd3);
    endtask

    task automatic handshake(input logic [7:0] b, input logic cmd_path, input string tag);
        req_up(b, cmd_path, tag);
        req_down(tag);
    endtask

    task automatic host_read(input logic [7:0] cmd, input logic cmd_path, input string tag);
        logic [3:0] a;
        logic       oor;
        a       = cmd[3:0];
        oor     = (cmd[6:4] != 3'b000);
        last_rd = oor ? 8'h00 : mdl[a];
        push_exp(last_rd, oor);
        handshake(cmd, cmd_path, tag);
    endtask

    task automatic host_write(input logic [7:0] cmd, input logic [7:0] data, input string tag);
        logic [3:0] a;
        logic       oor;
        a   = cmd[3:0];
        oor = (cmd[6:4] != 3'b000);
        push_exp(last_rd, oor);
        handshake(cmd, 1'b0, {tag, " cmd"});
        push_exp(last_rd, oor);
        handshake(data, 1'b0, {tag, " data"});
        if (!oor) mdl[a] = data;
    endtask

    task automatic end_burst();
`ifdef TT_PIN_RESPONDER_AUTOINC_EN
        @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        ena = 1'b1;
`endif
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        last_rd = 8'h00;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();

        // Reset state
        ena = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset uo_out", 32'(uo_out), 32'h00);
        check("reset uio_out", 32'(uio_out), 32'h00);
        check("reset uio_oe", 32'(uio_oe), 32'h06);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        host_read(8'h05, 1'b0, "rd05 after reset");

        // Write then read back
        host_write(8'h83, 8'hA5, "wr03");
        end_burst();
        host_read(8'h03, 1'b0, "rd03");
        host_read(8'h0A, 1'b0, "rd0A untouched");
        host_write(8'h8A, 8'h3C, "wr0A");
        end_burst();
        host_read(8'h0A, 1'b0, "rd0A");
        host_read(8'h03, 1'b0, "rd03 again");

        // Out-of-range accesses
        host_write(8'hC0, 8'h11, "wr oor");
        end_burst();
        host_read(8'h00, 1'b0, "rd00 after oor wr");
        host_read(8'h40, 1'b0, "rd oor");
        host_read(8'h03, 1'b0, "rd03 clears err");

        // ena drop while waiting for write data
        push_exp(last_rd, 1'b0);
        handshake(8'h85, 1'b0, "wr05 cmd");
        @(negedge clk);
        ena    = 1'b0;
        ui_in  = 8'h77;
        uio_in = 8'h01;
        repeat (5) @(posedge clk);
        #1;
        check("ena low ack", 32'(uio_out[1]), 32'd0);
        @(negedge clk);
        ena = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("held req no ack", 32'(uio_out[1]), 32'd0);
        check("ena uo_out kept", 32'(uo_out), 32'(last_rd));
        @(negedge clk);
        uio_in = 8'h00;
        repeat (5) @(posedge clk);
        #1;
        check("req drop no ack", 32'(uio_out[1]), 32'd0);
        host_read(8'h05, 1'b0, "rd05 after ena");

        // Asynchronous reset during the data acknowledge
        push_exp(last_rd, 1'b0);
        handshake(8'h83, 1'b0, "rst wr cmd");
        push_exp(last_rd, 1'b0);
        req_up(8'h5A, 1'b0, "rst wr data");
        rst_n = 1'b0;
        #1;
        check("async rst uio_out", 32'(uio_out), 32'h00);
        check("async rst uo_out", 32'(uo_out), 32'h00);
        uio_in = 8'h00;
        ui_in  = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        host_read(8'h03, 1'b0, "rd03 after rst");
        host_read(8'h0A, 1'b0, "rd0A after rst");

`ifdef TT_PIN_RESPONDER_AUTOINC_EN
        // Burst write with wrap, then a read issued through the command strobe
        begin
            logic [3:0] a;
            logic [7:0] d;
            a = 4'hE;
            push_exp(last_rd, 1'b0);
            handshake(8'h8E, 1'b0, "ai cmd");
            for (int k = 1; k <= 3; k++) begin
                d = 8'(k);
                push_exp(last_rd, 1'b0);
                handshake(d, 1'b0, "ai data");
                mdl[a] = d;
                a = a + 4'd1;
            end
            host_read(8'h0F, 1'b1, "ai cmd-path rd0F");
            host_read(8'h0E, 1'b0, "ai rd0E");
            host_read(8'h00, 1'b0, "ai rd00");
        end
`endif

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
